pll_lock_seq: RTL

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pll_lock_seq.sv
// PLL power-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the core reset. It retries the PLL reset on a lock timeout.
module pll_lock_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_CYCLES      = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retries
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B   = (RELEASE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RELEASE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Each state leaves on its last counted cycle, so the counter tops out at N-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     locked_s;
    logic                     cnt_clr;
    logic                     retry_inc;
    logic                     lost_nxt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= locked;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Priority: req_reset, then lock loss, then counter expiry.
    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        lost_nxt  = 1'b0;
        if (req_reset) begin
            state_nxt = PLL_RESET;
        end else begin
            case (state)
                PLL_RESET: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TO_LAST) begin
                        state_nxt = PLL_RESET;
                        retry_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s)                state_nxt = WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (!locked_s)                state_nxt = PLL_RESET;
                    else if (cnt == REL_LAST)     state_nxt = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = PLL_RESET;
                        lost_nxt  = 1'b1;
                    end
                end
                default: state_nxt = PLL_RESET;
            endcase
        end
        cnt_clr = req_reset || (state_nxt != state);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PLL_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            retries    <= 4'd0;
        end else begin
            state <= state_nxt;
            // RUN has no expiry, so the counter is parked there rather than wrapping.
            if (cnt_clr || state == RUN) cnt <= '0;
            else                         cnt <= cnt + CNT_W'(1);
            pll_rst    <= (state_nxt == PLL_RESET);
            core_reset <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            lock_lost  <= lost_nxt;
            if (retry_inc && retries != 4'hF) retries <= retries + 4'd1;
        end
    end

endmodule
